ir_scan_seq: RTL and testbench

- Controller that sequences the shared A2D interface and the three IR emitter enables to perform one full line-sensor scan.
- Per IR pair (inner, mid, outer): enable emitter, wait settle time, convert right then left channel.
- Accumulates a weighted steering error and hands it to the digital core's PID path with a one-cycle done pulse.
- Sits between dig_core's `go` and A2D_intf (strt_cnv/cnv_cmplt/chnnl/res).

---
 rtl/ir_scan_pkg.sv | 73 +++++++
 rtl/ir_settle_timer.sv | 28 ++
 rtl/ir_scan_seq.sv | 188 ++++++++++++++++++
 tb/tb_ir_scan_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_scan_pkg.sv
// Shared types and constants for the IR line-sensor scan sequencer:
// state encoding, A2D channel map, per-pair weights and the weighting helper.
package ir_scan_pkg;

    localparam int ERR_W = 16;
    localparam int RES_W = 12;

    localparam logic [2:0] CH_IN_R  = 3'd0;
    localparam logic [2:0] CH_IN_L  = 3'd1;
    localparam logic [2:0] CH_MID_R = 3'd2;
    localparam logic [2:0] CH_MID_L = 3'd4;
    localparam logic [2:0] CH_OUT_R = 3'd7;
    localparam logic [2:0] CH_OUT_L = 3'd3;

    localparam int W_IN  = 1;
    localparam int W_MID = 2;
    localparam int W_OUT = 4;

    localparam logic [1:0] LAST_PAIR = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CNV_R,
        ST_GUARD_R,
        ST_WAIT_R,
        ST_CNV_L,
        ST_GUARD_L,
        ST_WAIT_L,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic logic [2:0] right_ch(input logic [1:0] p);
        case (p)
            2'd0:    return CH_IN_R;
            2'd1:    return CH_MID_R;
            default: return CH_OUT_R;
        endcase
    endfunction

    function automatic logic [2:0] left_ch(input logic [1:0] p);
        case (p)
            2'd0:    return CH_IN_L;
            2'd1:    return CH_MID_L;
            default: return CH_OUT_L;
        endcase
    endfunction

    function automatic logic [2:0] pair_onehot(input logic [1:0] p);
        case (p)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Result is zero-extended, so the product is always a non-negative term
    function automatic logic signed [ERR_W-1:0] weighted(input logic [RES_W-1:0] res,
                                                         input logic [1:0] p);
        logic [ERR_W-1:0] r;
        logic [ERR_W-1:0] w;
        r = ERR_W'(res);
        case (p)
            2'd0:    w = ERR_W'(W_IN);
            2'd1:    w = ERR_W'(W_MID);
            default: w = ERR_W'(W_OUT);
        endcase
        return $signed(r * w);
    endfunction

endpackage

// File: rtl/ir_settle_timer.sv
// Loadable down-counter with terminal-count flag; shared by the emitter settle
// wait and the optional conversion timeout.
module ir_settle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/ir_scan_seq.sv
// IR line-sensor scan sequencer: per pair enable emitter, settle, convert R then L,
// accumulate weighted error. Optional conversion timeout under IR_SCAN_TIMEOUT_EN.
module ir_scan_seq
    import ir_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4096,
    parameter int TO_CYCLES     = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    output logic                    strt_cnv,
    output logic [2:0]              chnnl,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        A2D_res,
    output logic                    IR_in_en,
    output logic                    IR_mid_en,
    output logic                    IR_out_en,
    output logic signed [ERR_W-1:0] error,
    output logic                    scan_done,
    output logic                    busy,
    output logic                    scan_err
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TO_CYCLES) ? SETTLE_CYCLES : TO_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef IR_SCAN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TO_CYCLES - 1);
`endif

    state_t                  state, state_nxt;
    logic [1:0]              pair;
    logic signed [ERR_W-1:0] acc;
    logic [2:0]              ir_en;
    logic                    tmr_load, tmr_dec, tmr_tc;
    logic [CNT_W-1:0]        tmr_val;
`ifdef IR_SCAN_TIMEOUT_EN
    logic                    timeout;
`endif

    ir_settle_timer #(.W(CNT_W)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pair  <= '0;
            acc   <= '0;
            error <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && go) begin
                pair <= '0;
                acc  <= '0;
            end
            if (state == ST_WAIT_R && cnv_cmplt)
                acc <= acc + weighted(A2D_res, pair);
            if (state == ST_WAIT_L && cnv_cmplt)
                acc <= acc - weighted(A2D_res, pair);
            // error loads on entry to DONE so it is valid alongside scan_done
            if (state == ST_NEXT) begin
                if (pair == LAST_PAIR)
                    error <= acc;
                else
                    pair <= pair + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        strt_cnv  = 1'b0;
        chnnl     = 3'd0;
        ir_en     = 3'b000;
        scan_done = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = SETTLE_LOAD;
`ifdef IR_SCAN_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (go) begin
                    tmr_load  = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                ir_en   = pair_onehot(pair);
                tmr_dec = 1'b1;
                if (tmr_tc)
                    state_nxt = ST_CNV_R;
            end
            ST_CNV_R: begin
                ir_en     = pair_onehot(pair);
                strt_cnv  = 1'b1;
                chnnl     = right_ch(pair);
                state_nxt = ST_GUARD_R;
            end
            ST_GUARD_R: begin
                ir_en     = pair_onehot(pair);
                chnnl     = right_ch(pair);
                state_nxt = ST_WAIT_R;
`ifdef IR_SCAN_TIMEOUT_EN
                tmr_load  = 1'b1;
                tmr_val   = TO_LOAD;
`endif
            end
            ST_WAIT_R: begin
                ir_en = pair_onehot(pair);
                chnnl = right_ch(pair);
                if (cnv_cmplt)
                    state_nxt = ST_CNV_L;
`ifdef IR_SCAN_TIMEOUT_EN
                else begin
                    tmr_dec = 1'b1;
                    if (tmr_tc) begin
                        timeout   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
`endif
            end
            ST_CNV_L: begin
                ir_en     = pair_onehot(pair);
                strt_cnv  = 1'b1;
                chnnl     = left_ch(pair);
                state_nxt = ST_GUARD_L;
            end
            ST_GUARD_L: begin
                ir_en     = pair_onehot(pair);
                chnnl     = left_ch(pair);
                state_nxt = ST_WAIT_L;
`ifdef IR_SCAN_TIMEOUT_EN
                tmr_load  = 1'b1;
                tmr_val   = TO_LOAD;
`endif
            end
            ST_WAIT_L: begin
                ir_en = pair_onehot(pair);
                chnnl = left_ch(pair);
                if (cnv_cmplt)
                    state_nxt = ST_NEXT;
`ifdef IR_SCAN_TIMEOUT_EN
                else begin
                    tmr_dec = 1'b1;
                    if (tmr_tc) begin
                        timeout   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
`endif
            end
            ST_NEXT: begin
                if (pair == LAST_PAIR) begin
                    state_nxt = ST_DONE;
                end else begin
                    tmr_load  = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                scan_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign IR_in_en  = ir_en[0];
    assign IR_mid_en = ir_en[1];
    assign IR_out_en = ir_en[2];
    assign busy      = (state != ST_IDLE);
`ifdef IR_SCAN_TIMEOUT_EN
    assign scan_err  = timeout;
`else
    assign scan_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ir_scan_seq.sv
// Self-checking bench for ir_scan_seq: A2D responder model, output monitor and
// a reference error computed directly from the per-channel result table.
module tb_ir_scan_seq;

    localparam int SETTLE = 8;
    localparam int TO     = 20;

    logic               clk = 1'b0;
    logic               rst, go, cnv_cmplt;
    logic [11:0]        A2D_res;
    logic               strt_cnv, IR_in_en, IR_mid_en, IR_out_en, scan_done, busy, scan_err;
    logic [2:0]         chnnl;
    logic signed [15:0] error;

    ir_scan_seq #(.SETTLE_CYCLES(SETTLE), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .IR_in_en(IR_in_en),
        .IR_mid_en(IR_mid_en), .IR_out_en(IR_out_en), .error(error),
        .scan_done(scan_done), .busy(busy), .scan_err(scan_err)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int  tbl[8];
    bit  hang_ch4 = 0, hang_all = 0, stale_mode = 0;

    int                 strt_count, done_count, err_count;
    logic [2:0]         ch_q[$];
    logic [2:0]         en_q[$];
    bit                 two_hot, short_en;
    int                 en_run[3];
    logic [2:0]         mon_en;
    logic signed [15:0] done_err;

    localparam logic [17:0] EXP_CH = {3'd0, 3'd1, 3'd2, 3'd4, 3'd7, 3'd3};
    localparam logic [17:0] EXP_EN = {3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

    // error = sum over pairs of weight * (right - left)
    function automatic logic [15:0] ref_err();
        int e;
        e = 1 * (tbl[0] - tbl[1]) + 2 * (tbl[2] - tbl[4]) + 4 * (tbl[7] - tbl[3]);
        return e[15:0];
    endfunction

    task automatic clear_mon();
        strt_count = 0; done_count = 0; err_count = 0;
        ch_q.delete(); en_q.delete();
        two_hot = 0; short_en = 0;
    endtask

    // Monitor
    initial begin
        for (int i = 0; i < 3; i++) en_run[i] = 0;
        clear_mon();
        forever begin
            @(negedge clk);
            mon_en = {IR_out_en, IR_mid_en, IR_in_en};
            if ($countones(mon_en) > 1) two_hot = 1;
            for (int i = 0; i < 3; i++) en_run[i] = mon_en[i] ? en_run[i] + 1 : 0;
            if (strt_cnv) begin
                strt_count++;
                ch_q.push_back(chnnl);
                en_q.push_back(mon_en);
                if (chnnl == 3'd0 || chnnl == 3'd2 || chnnl == 3'd7) begin
                    int run;
                    run = mon_en[0] ? en_run[0] : mon_en[1] ? en_run[1] : mon_en[2] ? en_run[2] : 0;
                    if (run < SETTLE + 1) short_en = 1;
                end
            end
            if (scan_done) begin done_count++; done_err = error; end
            if (scan_err) err_count++;
        end
    end

    // A2D responder: completes no earlier than the first WAIT cycle
    initial begin
        cnv_cmplt = 0; A2D_res = '0;
        forever begin
            @(negedge clk);
            while (strt_cnv && !rst) begin
                logic [2:0] ch;
                int d;
                ch = chnnl;
                if (hang_all || (hang_ch4 && ch == 3'd4)) begin
                    @(negedge clk);
                end else begin
                    d = $urandom_range(0, 3);
                    if (stale_mode) begin
                        A2D_res = 12'd1234; cnv_cmplt = 1;
                        @(negedge clk);
                        @(negedge clk);
                        cnv_cmplt = 0;
                    end else begin
                        @(negedge clk);
                    end
                    repeat (d + 1) @(negedge clk);
                    A2D_res = tbl[ch][11:0]; cnv_cmplt = 1;
                    @(negedge clk);
                    cnv_cmplt = 0;
                end
            end
        end
    end

    task automatic pulse_go();
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
    endtask

    task automatic test_reset();
        rst = 1; go = 0;
        repeat (3) @(negedge clk);
        vectors++; if ({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en} !== 7'd0) begin miscompares++; $display("FAIL reset_ctl got=%b want=0", {strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en}); end
        vectors++; if (error !== 16'd0) begin miscompares++; $display("FAIL reset_error got=%0d want=0", error); end
        vectors++; if ({scan_done, busy, scan_err} !== 3'd0) begin miscompares++; $display("FAIL reset_status got=%b want=000", {scan_done, busy, scan_err}); end
        rst = 0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_scan_patterns();
        for (int p = 0; p < 12; p++) begin
            logic [15:0] exp;
            logic [17:0] chs, ens;
            bit got;
            for (int c = 0; c < 8; c++) begin
                case (p)
                    0: tbl[c] = 2048;
                    1: tbl[c] = (c == 0) ? 4095 : 0;
                    2: tbl[c] = (c == 3) ? 4095 : 0;
                    3: tbl[c] = (c == 0 || c == 2 || c == 7) ? 4095 : 0;
                    default: tbl[c] = $urandom_range(0, 4095);
                endcase
            end
            exp = ref_err();
            clear_mon();
            pulse_go();
            got = 0;
            for (int i = 0; i < 2000 && !got; i++) begin
                @(negedge clk);
                if (scan_done) got = 1;
            end
            repeat (3) @(negedge clk);
            chs = '0; ens = '0;
            foreach (ch_q[k]) chs = {chs[14:0], ch_q[k]};
            foreach (en_q[k]) ens = {ens[14:0], en_q[k]};
            vectors++; if (!got) begin miscompares++; $display("FAIL scan%0d_timeout no scan_done within bound", p); end
            vectors++; if (done_count !== 1) begin miscompares++; $display("FAIL scan%0d_done_count got=%0d want=1", p, done_count); end
            vectors++; if (done_err !== exp) begin miscompares++; $display("FAIL scan%0d_error got=%0d want=%0d", p, done_err, $signed(exp)); end
            vectors++; if (error !== exp) begin miscompares++; $display("FAIL scan%0d_error_hold got=%0d want=%0d", p, error, $signed(exp)); end
            vectors++; if (strt_count !== 6) begin miscompares++; $display("FAIL scan%0d_strt_count got=%0d want=6", p, strt_count); end
            vectors++; if (chs !== EXP_CH) begin miscompares++; $display("FAIL scan%0d_chnnl_seq got=%h want=%h", p, chs, EXP_CH); end
            vectors++; if (ens !== EXP_EN) begin miscompares++; $display("FAIL scan%0d_en_at_strt got=%h want=%h", p, ens, EXP_EN); end
            vectors++; if (two_hot !== 1'b0) begin miscompares++; $display("FAIL scan%0d_two_enables got=1 want=0", p); end
            vectors++; if (short_en !== 1'b0) begin miscompares++; $display("FAIL scan%0d_settle_short got=1 want=0", p); end
            vectors++; if ({busy, err_count} !== {1'b0, 32'd0}) begin miscompares++; $display("FAIL scan%0d_end_state busy=%b errs=%0d want 0/0", p, busy, err_count); end
        end
    endtask

    // go mid-scan and in DONE ignored; a stale cnv_cmplt level across CNV/GUARD ignored
    task automatic test_go_ignored();
        logic [15:0] exp;
        bit got;
        for (int c = 0; c < 8; c++) tbl[c] = (c == 0 || c == 2 || c == 7) ? 4095 : 0;
        exp = ref_err();
        stale_mode = 1;
        clear_mon();
        pulse_go();
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (scan_done) got = 1;
            else go = (i == 15 || i == 50);
        end
        go = 1;
        @(negedge clk); go = 0;
        repeat (40) @(negedge clk);
        stale_mode = 0;
        vectors++; if (!got) begin miscompares++; $display("FAIL go_ign_timeout no scan_done within bound"); end
        vectors++; if (done_count !== 1) begin miscompares++; $display("FAIL go_ign_done_count got=%0d want=1", done_count); end
        vectors++; if (strt_count !== 6) begin miscompares++; $display("FAIL go_ign_strt_count got=%0d want=6", strt_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL go_ign_busy got=%b want=0", busy); end
        vectors++; if (done_err !== exp) begin miscompares++; $display("FAIL guard_stale_error got=%0d want=%0d", done_err, $signed(exp)); end
    endtask

    task automatic test_reset_mid_scan();
        bit got;
        hang_ch4 = 1;
        clear_mon();
        pulse_go();
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (strt_cnv && chnnl == 3'd4) got = 1;
        end
        repeat (2) @(negedge clk);
        vectors++; if (!got) begin miscompares++; $display("FAIL rst_mid_reach never reached mid left conversion"); end
        vectors++; if ({chnnl, IR_mid_en, busy} !== {3'd4, 1'b1, 1'b1}) begin miscompares++; $display("FAIL rst_mid_wait_l got ch=%0d mid=%b busy=%b want 4/1/1", chnnl, IR_mid_en, busy); end
        vectors++; if (error !== 16'sd28665) begin miscompares++; $display("FAIL rst_mid_error_held got=%0d want=28665", error); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        vectors++; if ({strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, scan_done, busy, scan_err} !== 10'd0) begin miscompares++; $display("FAIL rst_mid_outputs got=%b want=0", {strt_cnv, chnnl, IR_in_en, IR_mid_en, IR_out_en, scan_done, busy, scan_err}); end
        vectors++; if (error !== 16'd0) begin miscompares++; $display("FAIL rst_mid_error got=%0d want=0", error); end
        hang_ch4 = 0;
        repeat (20) @(negedge clk);
        vectors++; if ({done_count, busy} !== {32'd0, 1'b0}) begin miscompares++; $display("FAIL rst_mid_after done=%0d busy=%b want 0/0", done_count, busy); end
    endtask

`ifdef IR_SCAN_TIMEOUT_EN
    task automatic test_timeout();
        logic signed [15:0] prev;
        int k;
        bit got;
        prev = error;
        hang_all = 1;
        clear_mon();
        pulse_go();
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (strt_cnv) got = 1;
        end
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            k++;
            if (scan_err) break;
        end
        vectors++; if (k !== TO + 1) begin miscompares++; $display("FAIL timeout_cycle got=%0d want=%0d", k, TO + 1); end
        @(negedge clk);
        hang_all = 0;
        vectors++; if ({busy, IR_in_en, IR_mid_en, IR_out_en} !== 4'd0) begin miscompares++; $display("FAIL timeout_idle got=%b want=0", {busy, IR_in_en, IR_mid_en, IR_out_en}); end
        vectors++; if ({done_count, err_count} !== {32'd0, 32'd1}) begin miscompares++; $display("FAIL timeout_pulses done=%0d err=%0d want 0/1", done_count, err_count); end
        vectors++; if (error !== prev) begin miscompares++; $display("FAIL timeout_error got=%0d want=%0d", error, prev); end
    endtask
`endif

    initial begin
        rst = 1; go = 0;
        for (int c = 0; c < 8; c++) tbl[c] = 0;
        test_reset();
        test_scan_patterns();
        test_go_ignored();
        test_reset_mid_scan();
`ifdef IR_SCAN_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
